stack_ctrl: RTL
===============

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, meaning the return-address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of stack entries (power of two, at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port push, input, 1 bit: store d as the new top (JCALL).
REQ-006 The block SHALL have port pop, input, 1 bit: remove the top entry (JR).
REQ-007 The block SHALL have port d, input, WIDTH bits: return address to push (PC+1).
REQ-008 The block SHALL have port q, output, WIDTH bits: current top-of-stack, feeding the s_pila PC mux leg.
REQ-009 The block SHALL have port empty, output, 1 bit: asserted when the stack holds 0 entries.
REQ-010 The block SHALL have port full, output, 1 bit: asserted when the stack holds DEPTH entries.
REQ-011 The block SHALL have port count, output, clog2(DEPTH)+1 bits: number of valid entries.
REQ-012 The block SHALL have port err, output, 1 bit: sticky overflow/underflow flag.

Function
REQ-013 Storage SHALL be DEPTH x WIDTH registers addressed by a clog2(DEPTH)-bit write pointer sp; sp SHALL wrap modulo DEPTH.
REQ-014 q SHALL be combinational: mem[sp-1] when count>0, and all-zeros when empty; a pop therefore sees the address in the same cycle, with zero latency.
REQ-015 A push only (push=1, pop=0, not full) SHALL write d to mem[sp], increment sp and increment count on the edge; q SHALL show d from the next cycle.
REQ-016 A pop only (push=0, pop=1, not empty) SHALL decrement sp and decrement count on the edge; the entry content SHALL be left unchanged.
REQ-017 A simultaneous push and pop with count>0 SHALL overwrite mem[sp-1] with d, leaving sp and count unchanged.
REQ-018 A simultaneous push and pop with count=0 SHALL be treated as a push only; no underflow SHALL be signalled.
REQ-019 A pop when empty (pop=1, push=0, count=0) SHALL change no state other than err, as given in Configuration.
REQ-020 A push when full (push=1, pop=0, count=DEPTH) SHALL follow the Configuration section.
REQ-021 empty SHALL equal (count==0) and full SHALL equal (count==DEPTH), both combinational from count.
REQ-022 push=0 and pop=0 SHALL hold all state.

Reset
REQ-023 While reset=1, sp, count and err SHALL be 0 immediately, without waiting for clk; consequently q=0, empty=1 and full=0.
REQ-024 Storage contents SHALL NOT be reset; they are masked by REQ-014.
REQ-025 Reset asserted mid-operation SHALL discard any push or pop in that cycle; the first operation SHALL take effect on the first rising edge after reset is released.

Configuration
REQ-026 With macro STACK_OVF_TRAP_EN defined, a push when full SHALL be ignored, with no state change except err set to 1.
REQ-027 With STACK_OVF_TRAP_EN defined, a pop when empty SHALL set err to 1; err SHALL remain 1 until reset.
REQ-028 With STACK_OVF_TRAP_EN undefined, a push when full SHALL write d to mem[sp] and increment sp (overwriting the oldest entry); count SHALL stay at DEPTH.
REQ-029 With STACK_OVF_TRAP_EN undefined, a pop when empty SHALL be ignored, err SHALL be tied to 0, and no error-flag register SHALL be built.

Verification
REQ-030 Scenario: after reset, push 0x011, 0x022, 0x033 -> count=3 and q=0x033; pop -> q=0x022 in the same cycle as the pop edge completes, count=2.
REQ-031 Scenario: with count=2 and top=0x022, push=pop=1 with d=0x3FF -> q=0x3FF and count=2; pop twice -> q=0x011, then empty=1 and q=0.
REQ-032 Scenario: push 8 times 0x001..0x008 -> full=1; a 9th push of 0x009 gives, with the macro, err=1, q=0x008, count=8; without the macro, q=0x009, count=8, and 8 pops return 0x009..0x002.
REQ-033 Scenario: pop when empty -> count=0 and q=0; err=1 with the macro, err=0 without; push=pop=1 when empty with d=0x055 -> count=1, q=0x055, no error.
REQ-034 Scenario: with count=5, assert reset asynchronously between clock edges -> count=0, empty=1, err=0 and q=0 before the next edge; push and pop held high during reset cause no change.

Source files
------------

// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl : return-address stack for JCALL/JR with zero-latency top-of-stack
// Optional macro STACK_OVF_TRAP_EN: trap overflow/underflow into sticky err.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stack_ctrl #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           d,
  output logic [WIDTH-1:0]           q,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);

  localparam int                c_AW       = $clog2(DEPTH);
  localparam logic [c_AW:0]     c_FULL_CNT = (c_AW+1)'(DEPTH);
  localparam logic [c_AW:0]     c_CNT_ONE  = (c_AW+1)'(1);
  localparam logic [c_AW-1:0]   c_SP_ONE   = c_AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_sp;
  logic [c_AW:0]    r_count;

  logic [c_AW-1:0]  w_sp_m1;
  logic             w_empty;
  logic             w_full;
  logic             w_wr_en;
  logic [c_AW-1:0]  w_wr_addr;
  logic             w_sp_inc;
  logic             w_sp_dec;
  logic             w_cnt_inc;
  logic             w_cnt_dec;
`ifdef STACK_OVF_TRAP_EN
  logic             w_err_set;
`endif

  assign w_sp_m1 = r_sp - c_SP_ONE;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL_CNT);

  // Operation decode; a push+pop on an empty stack degrades to a plain push.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_sp;
    w_sp_inc  = 1'b0;
    w_sp_dec  = 1'b0;
    w_cnt_inc = 1'b0;
    w_cnt_dec = 1'b0;
`ifdef STACK_OVF_TRAP_EN
    w_err_set = 1'b0;
`endif
    if (push && pop && !w_empty) begin
      w_wr_en   = 1'b1;
      w_wr_addr = w_sp_m1;
    end else if (push) begin
      if (!w_full) begin
        w_wr_en   = 1'b1;
        w_sp_inc  = 1'b1;
        w_cnt_inc = 1'b1;
      end else begin
`ifdef STACK_OVF_TRAP_EN
        w_err_set = 1'b1;
`else
        w_wr_en   = 1'b1;
        w_sp_inc  = 1'b1;
`endif
      end
    end else if (pop) begin
      if (!w_empty) begin
        w_sp_dec  = 1'b1;
        w_cnt_dec = 1'b1;
      end else begin
`ifdef STACK_OVF_TRAP_EN
        w_err_set = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sp    <= '0;
      r_count <= '0;
    end else begin
      if (w_sp_inc)
        r_sp <= r_sp + c_SP_ONE;
      else if (w_sp_dec)
        r_sp <= w_sp_m1;
      if (w_cnt_inc)
        r_count <= r_count + c_CNT_ONE;
      else if (w_cnt_dec)
        r_count <= r_count - c_CNT_ONE;
    end
  end

  // Storage is not reset; stale contents are hidden behind the count==0 mask on q.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_en)
      r_mem[w_wr_addr] <= d;
  end

`ifdef STACK_OVF_TRAP_EN
  logic r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_err <= 1'b0;
    else if (w_err_set)
      r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign q     = w_empty ? '0 : r_mem[w_sp_m1];
  assign empty = w_empty;
  assign full  = w_full;
  assign count = r_count;

endmodule

`default_nettype wire
